// File: rtl/rr_lock_arbiter.sv
// Four-requester round-robin arbiter with a bounded grant hold.
// An owner that hits the hold limit is revoked and locked out until it drops its request.
module rr_lock_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       timeout,
  output logic [1:0] timeout_id
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [3:0] mask_q, mask_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q;
  logic       timeout_q, timeout_d;
  logic [1:0] timeout_id_q, timeout_id_d;

  logic [3:0] eligible;
  logic [1:0] winner;
  logic [1:0] cand;

  assign eligible = req & ~mask_q;

  // Scan from the farthest offset back to ptr so the nearest eligible index wins.
  always_comb begin
    winner = ptr_q;
    cand   = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (eligible[cand]) winner = cand;
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
    timeout_id_d = 2'd0;
    mask_d       = mask_q & req;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << winner;
          owner_d = winner;
          ptr_d   = winner + 2'd1;
          cnt_d   = 8'd0;
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
        end else if (cnt_q == LIMIT) begin
          // Revoke: the owner's request is still high here, so the mask clear term cannot collide.
          state_d              = IDLE;
          gnt_d                = 4'b0000;
          timeout_d            = 1'b1;
          timeout_id_d         = owner_q;
          mask_d[owner_q]      = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      gnt_q        <= 4'b0000;
      mask_q       <= 4'b0000;
      ptr_q        <= 2'd0;
      owner_q      <= 2'd0;
      cnt_q        <= 8'd0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      timeout_id_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      mask_q       <= mask_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      busy_q       <= |gnt_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
    end
  end

  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;
  assign timeout_id = timeout_id_q;

endmodule

// File: doc/rr_lock_arbiter.md
RR_LOCK_ARBITER -- requirements
Module: rr_lock_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, maximum grant hold in cycles; legal range 2..255.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  level request per requester; bit i belongs to requester i.
REQ-005 gnt  output  4  registered one-hot grant, or all-zero.
REQ-006 busy  output  1  registered; high exactly when gnt is nonzero.
REQ-007 timeout  output  1  registered one-cycle pulse when a grant is forcibly revoked.
REQ-008 timeout_id  output  2  registered index of the revoked requester; valid only while timeout is high.

Function
REQ-009 The FSM SHALL have two states, IDLE and GRANT, and no other reachable state.
REQ-010 Eligible requesters SHALL be req & ~mask; mask is an internal 4-bit register.
REQ-011 In IDLE, any eligible requester at a clock edge SHALL move the FSM to GRANT, with gnt set to the winner at that edge, giving 1-cycle latency.
REQ-012 The winner SHALL be the first eligible index scanning ptr, ptr+1, ... modulo 4.
REQ-013 ptr SHALL be a 2-bit register that becomes winner+1 modulo 4 at each grant; ptr is unchanged in every other cycle.
REQ-014 In GRANT, gnt SHALL hold its value while req[owner] stays high and the hold count is below its limit.
REQ-015 In GRANT, if req[owner] is sampled low, the FSM SHALL go to IDLE and clear gnt at that edge.
REQ-016 There is no same-edge handover: after a release or revoke, at least one cycle with gnt=0 occurs before the next grant.
REQ-017 Hold counter cnt SHALL be 8 bits, load 0 on entry to GRANT, and increment by 1 each GRANT cycle; it never wraps.
REQ-018 In GRANT with req[owner] high and cnt equal to TIMEOUT-1, the next edge SHALL:
- clear gnt;
- go to IDLE;
- pulse timeout for one cycle;
- drive timeout_id with the owner index;
- set mask[owner].
As a result, gnt is high for exactly TIMEOUT cycles.
REQ-019 If req[owner] is low on the same edge where cnt equals TIMEOUT-1, this SHALL count as a release: no timeout pulse, and mask is unchanged.
REQ-020 mask[i] SHALL clear at any edge where req[i] is sampled low; a set and a clear of the same bit on one edge cannot occur.
REQ-021 A masked requester SHALL never be granted, even when it is the only requester.
REQ-022 Requests from non-owners during GRANT SHALL have no effect on gnt, cnt or ptr.
REQ-023 gnt SHALL never have more than one bit set in any cycle.

Reset
REQ-024 While reset is low, and immediately on its falling edge, the block SHALL hold:
- state = IDLE;
- gnt = 0, busy = 0;
- timeout = 0, timeout_id = 0;
- ptr = 0, cnt = 0, mask = 0.
REQ-025 Reset asserted mid-grant SHALL drop gnt asynchronously, with no timeout pulse.
REQ-026 After reset deasserts, the first arbitration SHALL occur at the first rising edge that samples reset high.

Verification
REQ-027 Single request: req=0001 at edge k -> gnt=0001 and busy=1 from edge k. Drop req at edge m -> gnt=0000 from edge m.
REQ-028 Round robin: req=1111 held, each owner releasing after 2 cycles -> grant order 0001, 0010, 0100, 1000, 0001, with a 1-cycle gap between grants.
REQ-029 Timeout: TIMEOUT=16, req=0100 held -> gnt=0100 for exactly 16 cycles, then timeout=1 with timeout_id=2 for 1 cycle. The held req never regrants until it is dropped for at least one cycle and raised again.
REQ-030 Release on the limit cycle: req[owner] falls at the edge where cnt=15 -> gnt clears, timeout stays 0, mask is unchanged.
REQ-031 Reset mid-grant: reset low while gnt=0010 -> gnt=0 immediately. After release with req=0011 -> gnt=0001, because ptr is back at 0.
REQ-032 Masked neighbour: requester 1 is timed out and keeps req high, requester 3 raises req -> gnt=1000 at the next IDLE edge, and requester 1 is skipped.
